// File: rtl/biriscv_mul_issue_arb_if.sv
// Issue-slot and writeback bundle between the two issue pipes and the
// shared-multiplier arbiter.
interface biriscv_mul_issue_arb_if;
   logic        req0_valid_i;
   logic [4:0]  req0_rd_i;
   logic        req0_ready_o;
   logic        req1_valid_i;
   logic [4:0]  req1_rd_i;
   logic        req1_ready_o;
   logic        hold_i;
   logic        flush_i;
   logic        mul_valid_o;
   logic        mul_sel_o;
   logic        rsp_valid_o;
   logic        rsp_port_o;
   logic [4:0]  rsp_rd_o;
   logic [31:0] pending_mask_o;
   logic        busy_o;

   modport slave (
      input  req0_valid_i, req0_rd_i, req1_valid_i, req1_rd_i, hold_i, flush_i,
      output req0_ready_o, req1_ready_o, mul_valid_o, mul_sel_o,
             rsp_valid_o, rsp_port_o, rsp_rd_o, pending_mask_o, busy_o
   );

   modport master (
      output req0_valid_i, req0_rd_i, req1_valid_i, req1_rd_i, hold_i, flush_i,
      input  req0_ready_o, req1_ready_o, mul_valid_o, mul_sel_o,
             rsp_valid_o, rsp_port_o, rsp_rd_o, pending_mask_o, busy_o
   );
endinterface

// File: rtl/biriscv_mul_issue_arb.sv
// Round-robin arbiter for the shared pipelined multiplier, with a shadow tag
// pipeline that tracks in-flight ops and produces the writeback strobe.
module biriscv_mul_issue_arb #(
   parameter int unsigned MUL_LATENCY = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   biriscv_mul_issue_arb_if.slave bus
);
   localparam int Lat = int'(MUL_LATENCY);

   logic [Lat-1:0] r_vld;
   logic [Lat-1:0] r_port;
   logic [4:0]     r_rd [Lat];
   logic           r_rr;

   logic        w_ok;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_any;
   logic [4:0]  w_rd;
   logic [31:0] w_mask;

   // Reset is folded in so the grant outputs drop without a clock edge.
   assign w_ok   = !bus.hold_i && !bus.flush_i && !rst_i;
   assign w_gnt0 = w_ok && bus.req0_valid_i && (!bus.req1_valid_i || !r_rr);
   assign w_gnt1 = w_ok && bus.req1_valid_i && (!bus.req0_valid_i || r_rr);
   assign w_any  = w_gnt0 || w_gnt1;
   assign w_rd   = w_gnt1 ? bus.req1_rd_i : (w_gnt0 ? bus.req0_rd_i : 5'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_vld  <= '0;
         r_port <= '0;
         r_rr   <= 1'b0;
         for (int k = 0; k < Lat; k++) begin
            r_rd[k] <= 5'd0;
         end
      end else begin
         // Pointer moves only on contested grants, to the loser.
         if (w_ok && bus.req0_valid_i && bus.req1_valid_i) begin
            r_rr <= ~w_gnt1;
         end
         if (bus.flush_i) begin
            r_vld <= '0;
         end else if (!bus.hold_i) begin
            r_vld   <= {r_vld[Lat-2:0], w_any};
            r_port  <= {r_port[Lat-2:0], w_gnt1};
            r_rd[0] <= w_rd;
            for (int k = 1; k < Lat; k++) begin
               r_rd[k] <= r_rd[k-1];
            end
         end
      end
   end

   always_comb begin
      w_mask = 32'd0;
      for (int k = 0; k < Lat; k++) begin
         if (r_vld[k]) begin
            w_mask[r_rd[k]] = 1'b1;
         end
      end
      w_mask[0] = 1'b0;
   end

   assign bus.req0_ready_o   = w_gnt0;
   assign bus.req1_ready_o   = w_gnt1;
   assign bus.mul_valid_o    = w_any;
   assign bus.mul_sel_o      = w_gnt1;
   assign bus.rsp_valid_o    = r_vld[Lat-1];
   assign bus.rsp_port_o     = r_vld[Lat-1] & r_port[Lat-1];
   assign bus.rsp_rd_o       = r_vld[Lat-1] ? r_rd[Lat-1] : 5'd0;
   assign bus.pending_mask_o = w_mask;
   assign bus.busy_o         = |r_vld;
endmodule

// File: doc/biriscv_mul_issue_arb.md
# biriscv_mul_issue_arb

Control-side arbiter and in-flight tracker for the shared pipelined integer multiplier in the dual-issue core. Two issue slots (pipe 0, pipe 1) request the single multiplier; the block grants at most one per cycle with round-robin fairness, and drives the multiplier operand-select and valid. It carries each accepted operation's tag (issuing port, destination register) down a shadow pipeline matching the multiplier latency, producing a response strobe aligned with the multiplier's writeback value. It also exports a pending-destination mask for hazard detection.

## Interface
- MUL_LATENCY, 2, cycles from accept edge to result valid; legal values 2 or 3, must equal the multiplier's stage setting
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req0_valid_i  in  1  pipe 0 has a MUL/MULH/MULHSU/MULHU ready to issue
- req0_rd_i  in  5  pipe 0 destination register index
- req0_ready_o  out  1  pipe 0 request accepted this cycle
- req1_valid_i  in  1  pipe 1 request
- req1_rd_i  in  5  pipe 1 destination register index
- req1_ready_o  out  1  pipe 1 request accepted this cycle
- hold_i  in  1  pipeline stall; freezes the multiplier and this block
- flush_i  in  1  squash all in-flight operations (branch mispredict / exception)
- mul_valid_o  out  1  to multiplier opcode_valid_i: an operation is accepted this cycle
- mul_sel_o  out  1  operand/opcode mux select: 0 = pipe 0 operands, 1 = pipe 1
- rsp_valid_o  out  1  multiplier writeback value is valid this cycle
- rsp_port_o  out  1  issuing port of the current response
- rsp_rd_o  out  5  destination register of the current response
- pending_mask_o  out  32  bit i set when a valid in-flight op targets x_i (bit 0 always 0)
- busy_o  out  1  any in-flight valid entry

## Operation
- Grant logic (combinational): accept allowed when hold_i=0 and flush_i=0.
  - Only one valid: grant it.
  - Both valid: grant port indicated by rr_ptr (reset 0).
  - req*_ready_o = grant to that port; mul_valid_o = any grant; mul_sel_o = granted port (0 when no grant).
- rr_ptr updates only on a contested grant: becomes the non-granted port. An uncontested grant leaves rr_ptr unchanged.
- Shadow pipeline: MUL_LATENCY entries {valid, port, rd}; stage 0 loads {grant, granted port, granted rd}; stage k loads stage k-1; advances only when hold_i=0.
- Response: rsp_valid_o/rsp_port_o/rsp_rd_o = last stage. When rsp_valid_o=0, port and rd read as 0.
- pending_mask_o = OR over valid stages of one-hot(rd), with bit 0 forced 0. busy_o = OR of stage valids.
- Flush:
  - At the edge where flush_i=1, all stage valids clear, regardless of hold_i.
  - No grant is issued in a flush cycle.
  - rr_ptr is unchanged.
- Hold: all state is frozen, no grant, and outputs hold their values (rsp_valid_o stays asserted if set).

## Timing
- Reset values: all stages invalid, rr_ptr=0, all outputs 0.
- Latency: request accepted in cycle T gives rsp_valid_o in cycle T+MUL_LATENCY, provided there is no hold. Each hold cycle adds one cycle.
- Throughput: one accept per cycle sustained. Back-to-back grants alternate ports when both requesters stay valid.
- Simultaneous hold_i and flush_i: flush wins. Stages clear and no grant is issued.
- Reset asserted mid-operation: in-flight state is discarded immediately (asynchronous), and outputs go to 0 without waiting for a clock.
- Requester that is not ready must hold valid/rd stable. The block does not buffer requests.

## Test plan
- Reset, then req0 only with rd=5 at cycle 1 → req0_ready_o=1, mul_sel_o=0 in cycle 1; rsp_valid_o=1, rsp_port_o=0, rsp_rd_o=5 in cycle 3 (MUL_LATENCY=2); pending_mask_o=0x20 in cycles 2–3.
- Both valid for 4 cycles, rd0=1, rd1=2 → grants in order port 0,1,0,1; responses in the same order 2 cycles later, with rsp_rd_o alternating 1,2.
- Accept at T, hold_i=1 in T+1 → rsp_valid_o delayed to T+3; no grant during the hold cycle even with req valid.
- Two ops in flight, flush_i=1 → rsp_valid_o never asserts for them; pending_mask_o=0 and busy_o=0 the next cycle; a request valid during the flush cycle is not accepted.
- req1 with rd=0 → rsp_valid_o asserts with rsp_rd_o=0; pending_mask_o stays 0 throughout.
- MUL_LATENCY=3, async rst_i pulse while 3 ops are in flight → all outputs 0 immediately; no responses follow.
